// File: rtl/pmic_capture_if.sv
// Signal bundle between the PMod MIC capture front end and its surroundings:
// ADC SPI pins, sampling controls, and the sample write port toward the FIFO.
// o_wr is a one-cycle valid with no ready: the sink must take o_data in the
// cycle o_wr is high. o_data stays stable until the next o_wr.
interface pmic_capture_if #(
  parameter int BW = 12
);
  logic          i_en;
  logic [15:0]   i_rate;
  logic          o_csn;
  logic          o_sck;
  logic          i_miso;
  logic          o_wr;
  logic [BW-1:0] o_data;
  logic          o_busy;
  logic [1:0]    o_state;

  modport master (
    input  i_en,
    input  i_rate,
    input  i_miso,
    output o_csn,
    output o_sck,
    output o_wr,
    output o_data,
    output o_busy,
    output o_state
  );

  modport slave (
    output i_en,
    output i_rate,
    output i_miso,
    input  o_csn,
    input  o_sck,
    input  o_wr,
    input  o_data,
    input  o_busy,
    input  o_state
  );
endinterface

// File: rtl/pmic_capture.sv
// SPI capture front end for an ADCS7476-class 12-bit ADC: a rate timer starts
// periodic 16-bit frames and each completed frame emits one BW-bit sample.
module pmic_capture #(
  parameter int BW    = 12,
  parameter int CKDIV = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  pmic_capture_if.master bus
);

  localparam int              MINRATE_I = 34 * CKDIV + 2;
  localparam logic [15:0]     MINRATE   = 16'(MINRATE_I);
  localparam int              HCW       = $clog2(CKDIV);
  localparam logic [HCW-1:0]  HC_LAST   = HCW'(CKDIV - 1);
  localparam logic [5:0]      HALF_LAST_SHIFT = 6'd31;
  localparam logic [5:0]      HALF_STOP = 6'd32;
  localparam logic [5:0]      HALF_WR   = 6'd33;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- timer
  logic [15:0] rate_clamped;
  logic [15:0] reload_val;
  logic [15:0] timer_q, timer_d;
  logic        start_w;

  always_comb begin
    rate_clamped = (bus.i_rate < MINRATE) ? MINRATE : bus.i_rate;
    reload_val   = rate_clamped - 16'd1;
    start_w      = bus.i_en && (timer_q == 16'd0);
    if (!bus.i_en || (timer_q == 16'd0)) begin
      timer_d = reload_val;
    end else begin
      timer_d = timer_q - 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_q <= reload_val;
    end else begin
      timer_q <= timer_d;
    end
  end

  // ------------------------------------------------------------- frame FSM
  // A frame is 34 SCK half-periods: half 0 is START, halves 1..31 are SHIFT
  // (odd halves drive SCK low), half 32 is the STOP hold, and half 33 is the
  // single write cycle with CS already released.
  state_t         state_q, state_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic [5:0]     half_q, half_d;
  logic           last_hc;

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    half_d  = half_q;
    last_hc = (hc_q == HC_LAST);
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          state_d = S_START;
          hc_d    = '0;
          half_d  = 6'd0;
        end
      end
      S_START: begin
        if (last_hc) begin
          state_d = S_SHIFT;
          hc_d    = '0;
          half_d  = 6'd1;
        end else begin
          hc_d = hc_q + HCW'(1);
        end
      end
      S_SHIFT: begin
        if (last_hc) begin
          hc_d   = '0;
          half_d = half_q + 6'd1;
          if (half_q == HALF_LAST_SHIFT) begin
            state_d = S_STOP;
          end
        end else begin
          hc_d = hc_q + HCW'(1);
        end
      end
      S_STOP: begin
        if (half_q == HALF_WR) begin
          state_d = S_IDLE;
          hc_d    = '0;
          half_d  = 6'd0;
        end else if (last_hc) begin
          hc_d   = '0;
          half_d = half_q + 6'd1;
        end else begin
          hc_d = hc_q + HCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
        half_d  = 6'd0;
      end
    endcase
  end

  // -------------------------------------------------------- output decode
  // Outputs are registered from the next-state values so the ADC pins come
  // straight off flops yet still change in the same cycle as the state.
  logic          csn_q, csn_d;
  logic          sck_q, sck_d;
  logic          busy_q, busy_d;
  logic          wr_q, wr_d;
  logic          frame_low_d;
  logic [BW-1:0] shift_q, shift_d;
  logic [BW-1:0] shift_in;
  logic [BW-1:0] data_q, data_d;

  // Only the last BW bits shifted in survive, which is exactly the low BW
  // bits of the 16-bit frame.
  if (BW > 1) begin : g_wide
    assign shift_in = {shift_q[BW-2:0], bus.i_miso};
  end else begin : g_narrow
    assign shift_in = bus.i_miso;
  end

  always_comb begin
    frame_low_d = (state_d == S_START) || (state_d == S_SHIFT) ||
                  ((state_d == S_STOP) && (half_d == HALF_STOP));
    csn_d  = !frame_low_d;
    busy_d = frame_low_d;
    sck_d  = !((state_d == S_SHIFT) && half_d[0]);
    wr_d   = (state_d == S_STOP) && (half_d == HALF_WR);

    shift_d = shift_q;
    if ((state_q == S_IDLE) && start_w) begin
      shift_d = '0;
    end else if (!sck_q && sck_d) begin
      shift_d = shift_in;
    end

    data_d = data_q;
    if (wr_d) begin
      data_d = shift_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
      half_q  <= 6'd0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      half_q  <= half_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_csn   = csn_q;
  assign bus.o_sck   = sck_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_wr    = wr_q;
  assign bus.o_data  = data_q;
  assign bus.o_state = state_q;

endmodule

// File: doc/pmic_capture.md
Name: pmic_capture

Overview:
- SPI capture front end for the MEMs PMod MIC (ADCS7476-class 12-bit serial ADC).
- Generates a periodic conversion frame (CS/SCK), shifts in 16 bits from MISO and emits one BW-bit sample per frame.
- Its o_wr/o_data outputs feed the sample FIFO's i_wr/i_data directly, one write pulse per sample.

Parameters:
- BW, 12, output sample width; legal range 1..16; takes the low BW bits of the 16-bit frame.
- CKDIV, 4, system clocks per SCK half-period; legal minimum 2.
- MINRATE, 34*CKDIV+2, minimum clocks between conversion starts (derived localparam, not overridable).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  enable periodic sampling
- i_rate  in  16  clocks per sample period (e.g. 2268 for 100MHz/44.1kHz)
- o_csn  out  1  ADC chip select, active low
- o_sck  out  1  ADC serial clock, idles high
- i_miso  in  1  ADC serial data
- o_wr  out  1  one-cycle sample-valid strobe (to FIFO i_wr)
- o_data  out  BW  captured sample (to FIFO i_data)
- o_busy  out  1  frame in progress

Behaviour:
Reset and idle state
- Reset values: o_csn=1, o_sck=1, o_wr=0, o_data=0, o_busy=0, state IDLE.
- On reset the timer loads R-1, where R = max(i_rate, MINRATE), 16-bit unsigned compare.
- Reset mid-frame aborts immediately: CS and SCK return high next cycle, no o_wr, partial shift data is discarded.

Timer
- While !i_en: the timer continuously reloads R-1.
- While i_en: decrements each cycle. At 0 it reloads R-1 and issues start (cycle t0).
- i_rate is sampled at every reload, so a change takes effect at the next period.

State machine (IDLE -> START -> SHIFT -> STOP -> IDLE)
- IDLE: waits for start.
- START: o_csn=0 and o_busy=1 from cycle t0+1. o_sck stays high for CKDIV cycles.
- SHIFT: 16 bit periods.
  - o_sck falls at t0+1+CKDIV+2k*CKDIV and rises CKDIV cycles later, k=0..15.
  - i_miso is shifted in MSB-first (shift left, LSB entry) on the clock edge at which o_sck goes high. 16th rising edge is at t0+1+32*CKDIV.
  - No input synchroniser; CKDIV>=2 guarantees setup.
- STOP: SCK held high for CKDIV more cycles.
  - At cycle t0+1+33*CKDIV: o_csn=1, o_busy=0, o_wr=1 for exactly one cycle, o_data=shift[BW-1:0] (4 leading frame zeros dropped for BW=12).
  - Returns to IDLE on the following cycle.
- o_data holds its value until the next o_wr.

Boundary conditions
- Clamp to MINRATE guarantees a start never arrives while busy. Back-to-back frames at R=MINRATE keep o_csn high for at least 1 cycle between frames.
- i_en falling mid-frame: the current frame completes and emits o_wr; no further starts.
- i_en rising: first start occurs R cycles later.
- o_wr is never asserted outside STOP. Exactly one o_wr per started, unaborted frame.
- No downstream backpressure: the FIFO handles overflow.

Test Plan:
- Reset: i_rst=1 for 3 cycles -> o_csn=1, o_sck=1, o_wr=0, o_data=0, o_busy=0 throughout.
- Single frame, CKDIV=4, i_rate=200, i_en=1, MISO model drives 16'h0AC3 MSB-first, changing on SCK fall -> o_wr pulses once with o_data=12'hAC3.
  - o_wr is exactly 133 cycles after the timer-zero cycle.
  - 16 SCK low pulses of 4 cycles each are seen.
- Periodicity: i_rate=200, 5 frames -> o_wr spacing exactly 200 cycles; data sequence 12'h000, 12'hFFF, 12'h555, 12'hAAA, 12'h001 reproduced.
- Clamp: i_rate=10 with CKDIV=4 -> o_wr spacing 138 cycles; o_csn high at least 1 cycle between frames; no frame overlap.
- Enable drop: deassert i_en at frame cycle 40 -> that frame still yields o_wr; no further o_csn falls for 1000 cycles.
- Reset mid-frame: assert i_rst at frame cycle 60 -> next cycle o_csn=1, o_sck=1, no o_wr.
  - After release with i_en=1, the first new o_wr occurs R+133 cycles after reset release.
